// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token constants, lock FSM state type,
// token lookup and data-word decode helpers.
package tmds_pkg;
    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] ctl;
    } token_t;

    function automatic token_t token_lookup(input logic [9:0] w);
        token_t t;
        t.hit = 1'b1;
        t.ctl = 2'b00;
        case (w)
            TOK_C00: t.ctl = 2'b00;
            TOK_C01: t.ctl = 2'b01;
            TOK_C10: t.ctl = 2'b10;
            TOK_C11: t.ctl = 2'b11;
            default: t.hit = 1'b0;
        endcase
        return t;
    endfunction

    // bit9 undoes the DC-balance inversion, bit8 selects XOR vs XNOR chaining
    function automatic logic [7:0] tmds_decode(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++)
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return d;
    endfunction
endpackage

// File: rtl/tmds_word_aligner.sv
// Word aligner: keeps the previous raw word and barrel-selects a 10-bit
// window starting at the current bit offset (0..9).
module tmds_word_aligner (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    input  logic [3:0] offset,
    output logic [9:0] aligned
);
    logic [9:0]  prev;
    logic [19:0] window;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) prev <= '0;
        else        prev <= tmds_in;
    end

    assign window = {tmds_in, prev};

    // constant-index selects keep every slice in range for any offset value
    always_comb begin
        aligned = window[9:0];
        for (int k = 1; k < 10; k++)
            if (offset == 4'(k)) aligned = window[k +: 10];
    end
endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit alignment search, lock FSM and 10b->8b decode.
// Define TMDS_DECODER_STATS_EN to expose offset_out and slips_out.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int LOCK_RUN   = 8,
    parameter int MISS_LIMIT = 2048
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] tmds_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       ve_out,
    output logic       locked_out
`ifdef TMDS_DECODER_STATS_EN
    ,
    output logic [3:0] offset_out,
    output logic [7:0] slips_out
`endif
);
    localparam int RUN_W  = $clog2(LOCK_RUN + 1);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, run_inc;
    logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
    logic [3:0]        offset_q, offset_d;
    logic [9:0]        aligned, word_q;
    token_t            tok;
    logic [7:0]        dec, data_d;
    logic [1:0]        ctl_d;
    logic              ve_d;

    tmds_word_aligner u_align (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tmds_in (tmds_in),
        .offset  (offset_q),
        .aligned (aligned)
    );

    assign tok      = token_lookup(word_q);
    assign dec      = tmds_decode(word_q);
    assign run_inc  = (run_q == RUN_W'(LOCK_RUN)) ? run_q : run_q + 1'b1;
    assign miss_inc = (miss_q == MISS_W'(MISS_LIMIT)) ? miss_q : miss_q + 1'b1;

    // a token always wins over the miss limit, so only non-tokens can slip
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        miss_d   = miss_q;
        offset_d = offset_q;
        if (tok.hit) begin
            miss_d = '0;
            if (state_q == SEARCH) begin
                run_d = run_inc;
                if (run_inc == RUN_W'(LOCK_RUN)) state_d = LOCKED;
            end
        end else begin
            if (state_q == SEARCH) run_d = '0;
            miss_d = miss_inc;
            if (miss_inc == MISS_W'(MISS_LIMIT)) begin
                state_d  = SEARCH;
                run_d    = '0;
                miss_d   = '0;
                offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            end
        end
    end

    always_comb begin
        data_d = '0;
        ctl_d  = '0;
        ve_d   = 1'b0;
        if (state_d == LOCKED) begin
            if (tok.hit) begin
                ctl_d = tok.ctl;
            end else begin
                ve_d   = 1'b1;
                data_d = dec;
                ctl_d  = control_out;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= SEARCH;
            run_q       <= '0;
            miss_q      <= '0;
            offset_q    <= '0;
            word_q      <= '0;
            data_out    <= '0;
            control_out <= '0;
            ve_out      <= 1'b0;
            locked_out  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            offset_q    <= offset_d;
            word_q      <= aligned;
            data_out    <= data_d;
            control_out <= ctl_d;
            ve_out      <= ve_d;
            locked_out  <= (state_d == LOCKED);
        end
    end

`ifdef TMDS_DECODER_STATS_EN
    logic [7:0] slips_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                                           slips_q <= '0;
        else if (offset_d != offset_q && slips_q != 8'hFF)    slips_q <= slips_q + 8'd1;
    end

    assign offset_out = offset_q;
    assign slips_out  = slips_q;
`endif
endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock timing, data decode, miss limit,
// offset search and asynchronous reset.
module tb_tmds_decoder;
    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic [9:0] tmds_in = '0;
    logic [7:0] data_out;
    logic [1:0] control_out;
    logic       ve_out;
    logic       locked_out;
`ifdef TMDS_DECODER_STATS_EN
    logic [3:0] offset_out;
    logic [7:0] slips_out;
`endif

    int vectors = 0;
    int miscompares = 0;
    int disp = 0;
    logic [9:0] true_prev = TOK0;

    tmds_decoder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .tmds_in     (tmds_in),
        .data_out    (data_out),
        .control_out (control_out),
        .ve_out      (ve_out),
        .locked_out  (locked_out)
`ifdef TMDS_DECODER_STATS_EN
        ,
        .offset_out  (offset_out),
        .slips_out   (slips_out)
`endif
    );

    initial forever #5 clk_in = ~clk_in;

    // present one raw word, return at the next falling edge
    task automatic drive(input logic [9:0] w);
        tmds_in = w;
        @(negedge clk_in);
    endtask

    // send true word t as a raw stream skewed by k bits
    task automatic drive_rot(input logic [9:0] t, input int k);
        logic [19:0] pair;
        pair = {t, true_prev};
        true_prev = t;
        drive(pair[(10 - k) +: 10]);
    endtask

    task automatic tmds_encode(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1d, n1, n0;
        n1d   = $countones(d);
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && !d[0])) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (disp == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp += (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp += (qm[8] ? 0 : -2) + n1 - n0;
        end
    endtask

    task automatic test_reset();
        #1 rst_in = 1'b1;
        drive(TOK0);
        drive(TOK0);
        vectors++; if (data_out !== 8'h00)    begin miscompares++; $display("FAIL reset_data: got %h want 00", data_out); end
        vectors++; if (control_out !== 2'b00) begin miscompares++; $display("FAIL reset_ctl: got %b want 00", control_out); end
        vectors++; if (ve_out !== 1'b0)       begin miscompares++; $display("FAIL reset_ve: got %b want 0", ve_out); end
        vectors++; if (locked_out !== 1'b0)   begin miscompares++; $display("FAIL reset_locked: got %b want 0", locked_out); end
`ifdef TMDS_DECODER_STATS_EN
        vectors++; if (offset_out !== 4'd0)   begin miscompares++; $display("FAIL reset_offset: got %0d want 0", offset_out); end
        vectors++; if (slips_out !== 8'd0)    begin miscompares++; $display("FAIL reset_slips: got %0d want 0", slips_out); end
`endif
        rst_in = 1'b0;
    endtask

    // 12 aligned tokens; the 8th token's lock shows two drives after it
    task automatic test_lock();
        for (int i = 0; i < 12; i++) begin
            drive(TOK0);
            if (i == 8) begin
                vectors++; if (locked_out !== 1'b0) begin miscompares++; $display("FAIL lock_early: got %b want 0", locked_out); end
            end
            if (i == 9) begin
                vectors++; if (locked_out !== 1'b1)   begin miscompares++; $display("FAIL lock_edge: got %b want 1", locked_out); end
                vectors++; if (control_out !== 2'b00) begin miscompares++; $display("FAIL lock_ctl: got %b want 00", control_out); end
                vectors++; if (ve_out !== 1'b0)       begin miscompares++; $display("FAIL lock_ve: got %b want 0", ve_out); end
                vectors++; if (data_out !== 8'h00)    begin miscompares++; $display("FAIL lock_data: got %h want 00", data_out); end
            end
        end
    endtask

    task automatic test_data();
        logic [9:0] seq [258];
        disp = 0;
        for (int b = 0; b < 256; b++) tmds_encode(8'(b), seq[b]);
        seq[256] = TOK0;
        seq[257] = TOK0;
        for (int i = 0; i < 258; i++) begin
            drive(seq[i]);
            if (i >= 2 && i < 258) begin
                vectors++; if (data_out !== 8'(i - 2)) begin miscompares++; $display("FAIL data_byte: got %h want %h", data_out, 8'(i - 2)); end
                vectors++; if (ve_out !== 1'b1)        begin miscompares++; $display("FAIL data_ve: got %b want 1 at byte %h", ve_out, 8'(i - 2)); end
            end
            if (i == 2) begin
                vectors++; if (control_out !== 2'b00) begin miscompares++; $display("FAIL data_ctl_hold: got %b want 00", control_out); end
            end
        end
    endtask

    // a token landing where the 2048th miss would be keeps lock
    task automatic test_miss_priority();
        logic [9:0] w;
        logic dropped;
        dropped = 1'b0;
        disp = 0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 0; i < 2047; i++) begin
                tmds_encode(8'(i * 7), w);
                drive(w);
                if (locked_out !== 1'b1) dropped = 1'b1;
            end
            drive(TOK0);
            if (locked_out !== 1'b1) dropped = 1'b1;
        end
        drive(TOK0);
        drive(TOK0);
        if (locked_out !== 1'b1) dropped = 1'b1;
        vectors++; if (dropped !== 1'b0)      begin miscompares++; $display("FAIL miss_prio_lock: dropped=%b want 0", dropped); end
        vectors++; if (control_out !== 2'b00) begin miscompares++; $display("FAIL miss_prio_ctl: got %b want 00", control_out); end
`ifdef TMDS_DECODER_STATS_EN
        vectors++; if (offset_out !== 4'd0)   begin miscompares++; $display("FAIL miss_prio_offset: got %0d want 0", offset_out); end
`endif
    endtask

    task automatic test_unlock();
        logic [9:0] w;
        int n;
        disp = 0;
        drive(TOK3);
        for (int i = 1; i <= 2050; i++) begin
            tmds_encode(8'(i), w);
            drive(w);
            if (i == 2) begin
                vectors++; if (control_out !== 2'b11) begin miscompares++; $display("FAIL unlock_tok_ctl: got %b want 11", control_out); end
                vectors++; if (ve_out !== 1'b0)       begin miscompares++; $display("FAIL unlock_tok_ve: got %b want 0", ve_out); end
            end
            if (i == 3) begin
                vectors++; if (control_out !== 2'b11) begin miscompares++; $display("FAIL unlock_ctl_hold: got %b want 11", control_out); end
                vectors++; if (ve_out !== 1'b1)       begin miscompares++; $display("FAIL unlock_data_ve: got %b want 1", ve_out); end
            end
            if (i == 2049) begin
                vectors++; if (locked_out !== 1'b1) begin miscompares++; $display("FAIL unlock_2047: got %b want 1", locked_out); end
            end
        end
        vectors++; if (locked_out !== 1'b0)   begin miscompares++; $display("FAIL unlock_2048: got %b want 0", locked_out); end
        vectors++; if (ve_out !== 1'b0)       begin miscompares++; $display("FAIL unlock_ve: got %b want 0", ve_out); end
        vectors++; if (control_out !== 2'b00) begin miscompares++; $display("FAIL unlock_ctl: got %b want 00", control_out); end
`ifdef TMDS_DECODER_STATS_EN
        vectors++; if (offset_out !== 4'd1)   begin miscompares++; $display("FAIL unlock_offset: got %0d want 1", offset_out); end
        vectors++; if (slips_out !== 8'd1)    begin miscompares++; $display("FAIL unlock_slips: got %0d want 1", slips_out); end
`endif
        // a 1-bit skewed stream only locks if the offset really moved to 1
        true_prev = TOK0;
        n = 0;
        while (locked_out !== 1'b1 && n < 40) begin
            drive_rot(TOK0, 1);
            n++;
        end
        vectors++; if (n < 9 || n > 12) begin miscompares++; $display("FAIL relock_offset1: locked after %0d words want 9..12", n); end
    endtask

    task automatic test_async_reset();
        vectors++; if (locked_out !== 1'b1) begin miscompares++; $display("FAIL pre_reset_locked: got %b want 1", locked_out); end
        #2 rst_in = 1'b1;
        #1;
        vectors++; if (locked_out !== 1'b0)   begin miscompares++; $display("FAIL async_locked: got %b want 0", locked_out); end
        vectors++; if (data_out !== 8'h00)    begin miscompares++; $display("FAIL async_data: got %h want 00", data_out); end
        vectors++; if (control_out !== 2'b00) begin miscompares++; $display("FAIL async_ctl: got %b want 00", control_out); end
        vectors++; if (ve_out !== 1'b0)       begin miscompares++; $display("FAIL async_ve: got %b want 0", ve_out); end
`ifdef TMDS_DECODER_STATS_EN
        vectors++; if (offset_out !== 4'd0)   begin miscompares++; $display("FAIL async_offset: got %0d want 0", offset_out); end
        vectors++; if (slips_out !== 8'd0)    begin miscompares++; $display("FAIL async_slips: got %0d want 0", slips_out); end
`endif
        @(negedge clk_in);
        rst_in = 1'b0;
        test_lock();
    endtask

    // stream skewed by 3: three full miss windows, then lock at offset 3
    task automatic test_slip_search();
        int n;
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        true_prev = TOK0;
        n = 0;
        while (locked_out !== 1'b1 && n < 7000) begin
            drive_rot(TOK0, 3);
            n++;
        end
        vectors++; if (n < 6150 || n > 6156)  begin miscompares++; $display("FAIL slip_lock_time: locked after %0d words want 6150..6156", n); end
        vectors++; if (control_out !== 2'b00) begin miscompares++; $display("FAIL slip_ctl: got %b want 00", control_out); end
`ifdef TMDS_DECODER_STATS_EN
        vectors++; if (offset_out !== 4'd3)   begin miscompares++; $display("FAIL slip_offset: got %0d want 3", offset_out); end
        vectors++; if (slips_out !== 8'd3)    begin miscompares++; $display("FAIL slip_count: got %0d want 3", slips_out); end
`endif
    endtask

    initial begin
        test_reset();
        test_lock();
        test_data();
        test_miss_priority();
        test_unlock();
        test_async_reset();
        test_slip_search();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
